// File: rtl/rf_dump.sv
// rf_dump: streams a contiguous, wrapping range of a 16-entry register file
// out over a valid/ready handshake.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, first_addr,      dump request; first_addr/count are sampled with
//   count                   start while IDLE (count 0..16)
//   rdAddr, rdData          register-file read port (rdData combinational)
//   out_valid, out_ready    word handshake; transfer when both high at posedge
//   out_data, out_addr      word being transferred and its register index
//   busy                    high whenever the controller is not IDLE
//   done                    one-cycle completion pulse
module rf_dump (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  first_addr,
  input  logic [4:0]  count,
  output logic [3:0]  rdAddr,
  input  logic [15:0] rdData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_addr,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DataW = 16;
  localparam int unsigned AddrW = 4;
  localparam int unsigned CntW  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [AddrW-1:0]  addr;
  logic [AddrW-1:0]  addrNext;
  logic [CntW-1:0]   remaining;
  logic [CntW-1:0]   remainingNext;
  logic              validNext;
  logic [DataW-1:0]  dataNext;
  logic [AddrW-1:0]  outAddrNext;
  logic              busyNext;
  logic              doneNext;

  // The read address is the address register itself, so it is registered
  // and always equal to addr.
  assign rdAddr = addr;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      addr      <= addrNext;
      remaining <= remainingNext;
      out_valid <= validNext;
      out_data  <= dataNext;
      out_addr  <= outAddrNext;
      busy      <= busyNext;
      done      <= doneNext;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    addrNext      = addr;
    remainingNext = remaining;
    validNext     = out_valid;
    dataNext      = out_data;
    outAddrNext   = out_addr;
    doneNext      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (count != CntW'(0)) begin
            addrNext      = first_addr;
            remainingNext = count;
            stateNext     = FETCH;
          end else begin
            stateNext = DONE;
          end
        end
      end

      // rdData already reflects addr here; capture it so later read-port
      // changes cannot disturb the word on offer.
      FETCH: begin
        dataNext    = rdData;
        outAddrNext = addr;
        validNext   = 1'b1;
        stateNext   = SEND;
      end

      SEND: begin
        if (out_ready) begin
          validNext     = 1'b0;
          remainingNext = remaining - CntW'(1);
          addrNext      = addr + AddrW'(1);
          stateNext     = (remaining == CntW'(1)) ? DONE : FETCH;
        end
      end

      // done is raised on the edge leaving DONE, the same edge busy drops.
      DONE: begin
        doneNext  = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_rf_dump.sv
module tb_rf_dump;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  first_addr;
  logic [4:0]  count;
  logic [3:0]  rdAddr;
  logic [15:0] rdData;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_addr;
  logic        busy;
  logic        done;

  logic [15:0] rfMod;
  int          vectors;
  int          miscompares;

  rf_dump dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .rdAddr     (rdAddr),
    .rdData     (rdData),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done)
  );

  // Register file model: R[i] = 0x1000 + i, optionally corrupted by rfMod.
  assign rdData = (16'h1000 + 16'(rdAddr)) ^ rfMod;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs a dump with out_ready held high; cycle k counts edges after the
  // start cycle. Word i is offered in cycle 2+2i, done pulses in 2+2*cnt.
  // A stray start is injected in cycle pokeAt (0 = none).
  task automatic runDump(input logic [3:0] fa, input int cnt, input int pokeAt);
    logic       expValid;
    logic [3:0] ea;
    int         idx;
    first_addr = fa;
    count      = 5'(cnt);
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    first_addr = 4'd0;
    count      = 5'd0;
    for (int k = 1; k <= 2 * cnt + 3; k++) begin
      expValid = (k >= 2) && (k % 2 == 0) && (k <= 2 * cnt);
      check("out_valid", 16'(out_valid), 16'(expValid));
      check("busy", 16'(busy), 16'(k <= 2 * cnt + 1));
      check("done", 16'(done), 16'(k == 2 * cnt + 2));
      if (expValid) begin
        idx = (k - 2) / 2;
        ea  = 4'(32'(fa) + idx);
        check("out_addr", 16'(out_addr), 16'(ea));
        check("out_data", out_data, 16'h1000 + 16'(ea));
      end else if ((k % 2 == 1) && (k <= 2 * cnt - 1)) begin
        idx = (k - 1) / 2;
        ea  = 4'(32'(fa) + idx);
        check("rdAddr", 16'(rdAddr), 16'(ea));
      end
      if (k == pokeAt) begin
        start      = 1'b1;
        first_addr = 4'd9;
        count      = 5'd1;
      end else begin
        start      = 1'b0;
        first_addr = 4'd0;
        count      = 5'd0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rfMod       = 16'h0000;
    reset_n     = 1'b0;
    start       = 1'b0;
    first_addr  = 4'd0;
    count       = 5'd0;
    out_ready   = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("rst out_valid", 16'(out_valid), 16'd0);
    check("rst out_data", out_data, 16'h0000);
    check("rst out_addr", 16'(out_addr), 16'd0);
    check("rst rdAddr", 16'(rdAddr), 16'd0);
    check("rst busy", 16'(busy), 16'd0);
    check("rst done", 16'(done), 16'd0);
    #10 reset_n = 1'b1;
    tick();

    // Basic dump: (2,1002) (3,1003) (4,1004); stray start in cycle 3 ignored.
    runDump(4'd2, 3, 3);

    // Wrapping dump: 14, 15, 0, 1.
    runDump(4'd14, 4, 0);

    // Zero-length request: no words, done two cycles after start.
    runDump(4'd5, 0, 0);

    // Back-pressure: first word held while out_ready is low and RF changes.
    first_addr = 4'd5;
    count      = 5'd2;
    out_ready  = 1'b0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("stall fetch valid", 16'(out_valid), 16'd0);
    tick();
    check("stall valid", 16'(out_valid), 16'd1);
    check("stall addr", 16'(out_addr), 16'd5);
    check("stall data", out_data, 16'h1005);
    rfMod = 16'hFFFF;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("stall hold valid", 16'(out_valid), 16'd1);
      check("stall hold addr", 16'(out_addr), 16'd5);
      check("stall hold data", out_data, 16'h1005);
      check("stall no done", 16'(done), 16'd0);
    end
    rfMod     = 16'h0000;
    out_ready = 1'b1;
    tick();
    check("stall accepted", 16'(out_valid), 16'd0);
    tick();
    check("stall 2nd valid", 16'(out_valid), 16'd1);
    check("stall 2nd addr", 16'(out_addr), 16'd6);
    check("stall 2nd data", out_data, 16'h1006);
    tick();
    check("stall tail valid", 16'(out_valid), 16'd0);
    check("stall tail busy", 16'(busy), 16'd1);
    tick();
    check("stall done", 16'(done), 16'd1);
    check("stall idle", 16'(busy), 16'd0);
    tick();
    check("stall done once", 16'(done), 16'd0);

    // Asynchronous reset during the second word of a count=8 dump.
    first_addr = 4'd0;
    count      = 5'd8;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    tick();
    tick();
    tick();
    check("pre-rst valid", 16'(out_valid), 16'd1);
    check("pre-rst addr", 16'(out_addr), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid-rst valid", 16'(out_valid), 16'd0);
    check("mid-rst data", out_data, 16'h0000);
    check("mid-rst addr", 16'(out_addr), 16'd0);
    check("mid-rst rdAddr", 16'(rdAddr), 16'd0);
    check("mid-rst busy", 16'(busy), 16'd0);
    check("mid-rst done", 16'(done), 16'd0);
    #2 reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("post-rst busy", 16'(busy), 16'd0);
      check("post-rst done", 16'(done), 16'd0);
      check("post-rst valid", 16'(out_valid), 16'd0);
    end
    runDump(4'd7, 2, 0);

    // Full sweep of all 16 registers.
    runDump(4'd0, 16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_dump.md
RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 SHALL have no parameters; data width fixed at 16 bits, register address fixed at 4 bits (16 registers).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  dump request, sampled only in IDLE.
REQ-005 first_addr  input  4  first register index to read, sampled with start.
REQ-006 count  input  5  number of registers to dump (0..16), sampled with start.
REQ-007 rdAddr  output  4  read address driven to a register-file read port.
REQ-008 rdData  input  16  combinational read data for rdAddr, valid in the same cycle.
REQ-009 out_valid  output  1  out_data/out_addr hold a word to transfer.
REQ-010 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high at posedge.
REQ-011 out_data  output  16  register contents being transferred.
REQ-012 out_addr  output  4  index of the register in out_data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  single-cycle pulse marking dump completion.

Function
REQ-015 SHALL implement a state machine with states IDLE, FETCH, SEND and DONE.
REQ-016 IDLE with start=1 and count!=0 SHALL latch addr=first_addr and remaining=count, then go to FETCH.
REQ-017 IDLE with start=1 and count=0 SHALL go to DONE without ever asserting out_valid.
REQ-018 start SHALL be ignored in all states except IDLE; first_addr and count SHALL be ignored except when sampled with start.
REQ-019 rdAddr SHALL be a registered output equal to the internal addr register at all times.
REQ-020 FETCH SHALL capture rdData into out_data and addr into out_addr, set out_valid=1, and go to SEND; the FETCH cycle lasts one cycle.
REQ-021 SEND SHALL hold out_valid, out_data and out_addr stable until out_ready=1; rdData changes during SEND SHALL NOT alter out_data.
REQ-022 On the accept cycle in SEND, the block SHALL clear out_valid, decrement remaining, and set addr=addr+1 modulo 16 (15 wraps to 0).
REQ-023 After an accept, remaining=1 (pre-decrement) SHALL go to DONE; otherwise the block SHALL go to FETCH.
REQ-024 Throughput SHALL be one word per two cycles with out_ready held high; first out_valid SHALL rise two cycles after the start cycle.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; busy SHALL fall in the same edge.
REQ-026 count=16 SHALL dump all 16 registers, starting at first_addr and wrapping through 15 to 0.
REQ-027 out_valid SHALL never be high outside SEND; done and out_valid SHALL never be high in the same cycle.

Reset
REQ-028 reset_n=0 SHALL immediately, independent of clk, force state=IDLE, addr=0, remaining=0, rdAddr=0, out_valid=0, out_data=0, out_addr=0, busy=0 and done=0.
REQ-029 Reset asserted mid-dump SHALL abort the dump with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-030 RF preloaded with R[i]=16'h1000+i; start with first_addr=2 and count=3, out_ready=1 -> words (2,1002), (3,1003), (4,1004), one per two cycles, then a single done pulse and busy=0.
REQ-031 start with first_addr=14 and count=4 -> out_addr sequence 14, 15, 0, 1 with matching data.
REQ-032 out_ready low for 5 cycles during the first word -> out_valid stays high and out_data/out_addr stay stable the whole time; the same word is accepted exactly once.
REQ-033 start with count=0 -> no out_valid; done pulses 2 cycles after the start cycle; a start pulse while busy -> ignored, with the in-flight sequence unchanged.
REQ-034 reset_n pulsed low between clock edges during the second word of a count=8 dump -> all outputs are 0 immediately; no done pulse; a new dump then runs correctly.
REQ-035 count=16, first_addr=0 -> 16 words, addresses 0..15 in order, data matching the RF; done asserted once.
